// File: rtl/adc_frame_packer_pkg.sv
// Shared types and constants for the ADC frame packer: FSM states, header layout, pad word.
package adc_frame_packer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_PAD
    } state_t;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA55A;
    localparam logic [31:0] PAD_WORD          = 32'hFFFF_FFFF;

    localparam int unsigned HDR_MAGIC_LSB = 16;
    localparam int unsigned HDR_SEQ_LSB   = 8;
    localparam int unsigned HDR_DROP_LSB  = 0;

    function automatic logic [31:0] make_header(input logic [15:0] magic,
                                                input logic [7:0]  seq,
                                                input logic [7:0]  drops);
        logic [31:0] hdr;
        hdr                       = '0;
        hdr[HDR_MAGIC_LSB +: 16]  = magic;
        hdr[HDR_SEQ_LSB   +: 8]   = seq;
        hdr[HDR_DROP_LSB  +: 8]   = drops;
        return hdr;
    endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample input and FIFO write-side bundle; master is the packer, slave the surrounding logic.
interface adc_frame_packer_if;

    logic        sample_valid;
    logic [15:0] sample_data;
    logic [7:0]  fifo_wr_count;
    logic        fifo_we;
    logic [31:0] fifo_data;

    modport master (
        input  sample_valid,
        input  sample_data,
        input  fifo_wr_count,
        output fifo_we,
        output fifo_data
    );

    modport slave (
        output sample_valid,
        output sample_data,
        output fifo_wr_count,
        input  fifo_we,
        input  fifo_data
    );

endinterface

// File: rtl/adc_frame_packer.sv
// Packs 16-bit samples two per word into fixed frames (header + data words) for the DDR input FIFO.
module adc_frame_packer
    import adc_frame_packer_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 10,
    parameter int unsigned FIFO_DEPTH  = 256,
    parameter logic [15:0] HDR_MAGIC   = HDR_MAGIC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    adc_frame_packer_if.master  bus,
    output logic [7:0]          frame_seq,
    output logic [15:0]         drop_total,
    output logic                busy
);

    localparam logic [5:0]  LAST_DATA = 6'(FRAME_WORDS - 1);
    localparam int unsigned ROOM_MAX  = FIFO_DEPTH - FRAME_WORDS - 2;

    state_t      state, state_nx;
    logic [5:0]  word_cnt, word_cnt_nx;
    logic [15:0] low_half, low_half_nx;
    logic [7:0]  drop_since_last, drop_since_last_nx;
    logic [7:0]  frame_seq_nx;
    logic [15:0] drop_total_nx;
    logic        we_q, we_nx;
    logic [31:0] data_q, data_nx;
    logic        room;
    logic        count_drop;

    assign room        = (32'(bus.fifo_wr_count) <= ROOM_MAX);
    assign busy        = (state != S_IDLE);
    assign bus.fifo_we   = we_q;
    assign bus.fifo_data = data_q;

    always_comb begin
        state_nx           = state;
        word_cnt_nx        = word_cnt;
        low_half_nx        = low_half;
        drop_since_last_nx = drop_since_last;
        frame_seq_nx       = frame_seq;
        drop_total_nx      = drop_total;
        we_nx              = 1'b0;
        data_nx            = data_q;
        count_drop         = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.sample_valid && enable) begin
                    if (room) begin
                        we_nx              = 1'b1;
                        data_nx            = make_header(HDR_MAGIC, frame_seq, drop_since_last);
                        drop_since_last_nx = '0;
                        low_half_nx        = bus.sample_data;
                        word_cnt_nx        = '0;
                        state_nx           = S_HI;
                    end else begin
                        count_drop = 1'b1;
                    end
                end
            end
            S_LO: begin
                if (bus.sample_valid) begin
                    low_half_nx = bus.sample_data;
                    state_nx    = S_HI;
                end else if (!enable) begin
                    state_nx = S_PAD;
                end
            end
            S_HI: begin
                // A missing high half on disable is filled with 16'hFFFF so the word still counts.
                if (bus.sample_valid || !enable) begin
                    we_nx       = 1'b1;
                    data_nx     = {(bus.sample_valid ? bus.sample_data : 16'hFFFF), low_half};
                    word_cnt_nx = word_cnt + 6'd1;
                    if (word_cnt_nx == LAST_DATA) begin
                        frame_seq_nx = frame_seq + 8'd1;
                        state_nx     = S_IDLE;
                    end else if (bus.sample_valid) begin
                        state_nx = S_LO;
                    end else begin
                        state_nx = S_PAD;
                    end
                end
            end
            S_PAD: begin
                we_nx       = 1'b1;
                data_nx     = PAD_WORD;
                word_cnt_nx = word_cnt + 6'd1;
                count_drop  = bus.sample_valid;
                if (word_cnt_nx == LAST_DATA) begin
                    frame_seq_nx = frame_seq + 8'd1;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (count_drop) begin
            if (drop_since_last != '1) drop_since_last_nx = drop_since_last + 8'd1;
            if (drop_total != '1)      drop_total_nx      = drop_total + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            word_cnt        <= '0;
            low_half        <= '0;
            drop_since_last <= '0;
            frame_seq       <= '0;
            drop_total      <= '0;
            we_q            <= 1'b0;
            data_q          <= '0;
        end else begin
            state           <= state_nx;
            word_cnt        <= word_cnt_nx;
            low_half        <= low_half_nx;
            drop_since_last <= drop_since_last_nx;
            frame_seq       <= frame_seq_nx;
            drop_total      <= drop_total_nx;
            we_q            <= we_nx;
            data_q          <= data_nx;
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer: scoreboard of expected FIFO words plus table-driven start cases.
module tb_adc_frame_packer;
    import adc_frame_packer_pkg::*;

    localparam int unsigned FW    = 10;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned DATA  = FW - 1;

    typedef struct {
        logic [7:0] cnt;
        logic       en;
        logic       valid;
        logic       exp_write;
        logic       exp_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable;
    logic [7:0]  frame_seq;
    logic [15:0] drop_total;
    logic        busy;

    adc_frame_packer_if bus();

    adc_frame_packer #(
        .FRAME_WORDS(FW),
        .FIFO_DEPTH (DEPTH),
        .HDR_MAGIC  (16'hA55A)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .bus       (bus.master),
        .frame_seq (frame_seq),
        .drop_total(drop_total),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int unsigned wr_cyc[$];
    int unsigned cyc = 0;
    logic [31:0] mon_exp;

    logic [7:0]  m_seq;
    logic [7:0]  m_dsl;
    logic [15:0] m_total;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fifo_we === 1'b1) begin
            checks++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got=%08h expected=no_write", bus.fifo_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.fifo_data !== mon_exp) begin
                    failures++;
                    $display("FAIL fifo_word got=%08h expected=%08h", bus.fifo_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic en);
        bus.sample_valid = v;
        bus.sample_data  = d;
        enable           = en;
        @(posedge clk);
        #1;
    endtask

    task automatic push_header();
        exp_q.push_back({16'hA55A, m_seq, m_dsl});
        m_dsl = '0;
    endtask

    task automatic end_frame();
        m_seq = m_seq + 8'd1;
    endtask

    task automatic model_drop();
        if (m_dsl != 8'hFF)      m_dsl   = m_dsl + 8'd1;
        if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        bus.sample_valid = 1'b0;
        enable           = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_pending_words"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        bus.sample_valid   = 1'b0;
        bus.sample_data    = '0;
        bus.fifo_wr_count  = '0;
        enable             = 1'b0;
        reset_n            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_seq   = '0;
        m_dsl   = '0;
        m_total = '0;
    endtask

    // n samples with enable high; a short frame is then closed by dropping enable.
    task automatic run_frame(input logic [15:0] base, input int unsigned n);
        logic [15:0] d, prev;
        int unsigned words;
        prev = '0;
        for (int unsigned i = 0; i < n; i++) begin
            d = base + 16'(i);
            if (i == 0)          push_header();
            else if (i % 2 == 1) exp_q.push_back({d, prev});
            prev = d;
            cycle(1'b1, d, 1'b1);
        end
        end_frame();
        if (n < 2 * DATA) begin
            if (n % 2 == 1) exp_q.push_back({16'hFFFF, prev});
            words = (n + 1) / 2;
            for (int unsigned k = words; k < DATA; k++) exp_q.push_back(PAD_WORD);
            drain("partial_frame");
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{cnt: 8'd0,   en: 1'b1, valid: 1'b1, exp_write: 1'b1, exp_drop: 1'b0};
        vecs[1] = '{cnt: 8'd245, en: 1'b1, valid: 1'b1, exp_write: 1'b0, exp_drop: 1'b1};
        vecs[2] = '{cnt: 8'd255, en: 1'b1, valid: 1'b1, exp_write: 1'b0, exp_drop: 1'b1};
        vecs[3] = '{cnt: 8'd244, en: 1'b1, valid: 1'b1, exp_write: 1'b1, exp_drop: 1'b0};
        vecs[4] = '{cnt: 8'd0,   en: 1'b0, valid: 1'b1, exp_write: 1'b0, exp_drop: 1'b0};
        vecs[5] = '{cnt: 8'd247, en: 1'b0, valid: 1'b1, exp_write: 1'b0, exp_drop: 1'b0};
        vecs[6] = '{cnt: 8'd0,   en: 1'b1, valid: 1'b0, exp_write: 1'b0, exp_drop: 1'b0};
        vecs[7] = '{cnt: 8'd247, en: 1'b1, valid: 1'b1, exp_write: 1'b0, exp_drop: 1'b1};

        do_reset();
        chk("reset_fifo_we",    32'(bus.fifo_we), 32'd0);
        chk("reset_fifo_data",  bus.fifo_data,    32'd0);
        chk("reset_frame_seq",  32'(frame_seq),   32'd0);
        chk("reset_drop_total", 32'(drop_total),  32'd0);
        chk("reset_busy",       32'(busy),        32'd0);

        // Full frame of 18 consecutive samples
        run_frame(16'h0001, 2 * DATA);
        drain("full_frame");
        chk("full_frame_seq", 32'(frame_seq), 32'(m_seq));

        // No room: five drops, then a frame whose header carries the drop count
        bus.fifo_wr_count = 8'd247;
        for (int i = 0; i < 5; i++) begin
            model_drop();
            cycle(1'b1, 16'h00F0 + 16'(i), 1'b1);
        end
        chk("no_room_drop_total", 32'(drop_total), 32'(m_total));
        bus.fifo_wr_count = 8'd0;
        run_frame(16'h0100, 2 * DATA);
        drain("after_drops");

        // Enable drops after three samples
        run_frame(16'h0001, 3);
        chk("disable_frame_seq", 32'(frame_seq), 32'(m_seq));

        // Frame-start table: room boundary, enable gating, drop counting
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d;
            d = 16'h1000 + 16'(i);
            bus.fifo_wr_count = vecs[i].cnt;
            if (vecs[i].exp_write) begin
                push_header();
                exp_q.push_back({16'hFFFF, d});
                for (int unsigned k = 1; k < DATA; k++) exp_q.push_back(PAD_WORD);
                end_frame();
            end
            if (vecs[i].exp_drop) model_drop();
            cycle(vecs[i].valid, d, vecs[i].en);
            chk("vec_header_we",  32'(bus.fifo_we),  32'(vecs[i].exp_write));
            chk("vec_drop_total", 32'(drop_total),   32'(m_total));
            bus.fifo_wr_count = 8'd0;
            drain("vec");
        end

        // Samples during padding are dropped; once idle with enable low they are ignored
        push_header();
        exp_q.push_back({16'hFFFF, 16'h0700});
        for (int unsigned k = 1; k < DATA; k++) exp_q.push_back(PAD_WORD);
        end_frame();
        cycle(1'b1, 16'h0700, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0);
        for (int unsigned k = 0; k < DATA + 1; k++) begin
            if (k < DATA - 1) model_drop();
            cycle(1'b1, 16'h0800 + 16'(k), 1'b0);
        end
        drain("pad_drops");
        chk("pad_drop_total", 32'(drop_total), 32'(m_total));

        // Back-to-back frames: next header in the cycle after the last word
        wr_cyc.delete();
        run_frame(16'h0200, 2 * DATA);
        run_frame(16'h0300, 2 * DATA);
        drain("back_to_back");
        chk("b2b_write_count", 32'(wr_cyc.size()), 32'(2 * FW));
        if (wr_cyc.size() == 2 * FW)
            chk("b2b_header_gap", wr_cyc[FW] - wr_cyc[FW - 1], 32'd1);

        // Sequence wrap: 257th header after reset carries seq 0
        do_reset();
        for (int i = 0; i < 256; i++) run_frame(16'(i * 32), 2 * DATA);
        drain("wrap");
        chk("wrap_frame_seq", 32'(frame_seq), 32'd0);
        run_frame(16'hC000, 2 * DATA);
        drain("wrap_257");

        // drop_since_last saturates at 8'hFF
        bus.fifo_wr_count = 8'd247;
        for (int i = 0; i < 300; i++) begin
            model_drop();
            cycle(1'b1, 16'(i), 1'b1);
        end
        chk("sat_drop_total", 32'(drop_total), 32'(m_total));
        bus.fifo_wr_count = 8'd0;
        run_frame(16'hD000, 2 * DATA);
        drain("sat_frame");

        // Asynchronous reset while the fifth word is on the bus
        push_header();
        for (int unsigned i = 0; i < 8; i++) begin
            if (i % 2 == 1 && i < 7)
                exp_q.push_back({16'h0400 + 16'(i), 16'h0400 + 16'(i - 1)});
            cycle(1'b1, 16'h0400 + 16'(i), 1'b1);
        end
        chk("pre_reset_we",   32'(bus.fifo_we), 32'd1);
        chk("pre_reset_data", bus.fifo_data,    32'h0407_0406);
        reset_n = 1'b0;
        #1;
        chk("midreset_fifo_we",    32'(bus.fifo_we), 32'd0);
        chk("midreset_fifo_data",  bus.fifo_data,    32'd0);
        chk("midreset_frame_seq",  32'(frame_seq),   32'd0);
        chk("midreset_drop_total", 32'(drop_total),  32'd0);
        chk("midreset_busy",       32'(busy),        32'd0);
        do_reset();
        repeat (5) cycle(1'b0, 16'h0000, 1'b1);
        chk("post_reset_pending", 32'(exp_q.size()), 32'd0);
        run_frame(16'h0500, 2 * DATA);
        drain("post_reset_frame");
        chk("post_reset_seq", 32'(frame_seq), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
